p4_instr_feeder: RTL and testbench
==================================

// Module: p4_instr_feeder
// PURPOSE
//  Host-side initiator for the p4_cpu load/s/w handshake. Buffers 16-bit instructions
//  in a FIFO, presents each to the CPU (load pulse, then s pulse), waits for the busy
//  cycle (w low -> w high), captures out and N/V/Z into a result slot, then launches
//  the next one. Sits between the testbench/switch front-end and p4_cpu.
// PARAMETERS
//  DEPTH           4    FIFO entries; power of two, >= 2.
//  TIMEOUT_CYCLES  64   Watchdog limit in cycles; used only with FEEDER_TIMEOUT_EN.
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    asynchronous, active-high
//  wr_en      in   1    push wr_data into FIFO
//  wr_data    in   16   instruction to queue
//  full       out  1    FIFO holds DEPTH entries
//  empty      out  1    FIFO holds 0 entries
//  overflow   out  1    sticky: a push was dropped
//  cpu_in     out  16   to CPU in
//  cpu_load   out  1    to CPU load
//  cpu_s      out  1    to CPU s
//  cpu_w      in   1    from CPU w (1 = CPU in WAIT)
//  cpu_out    in   16   from CPU out
//  cpu_N/V/Z  in   1    from CPU flags (three 1-bit ports)
//  res_data   out  16   captured cpu_out
//  res_flags  out  3    captured {N,V,Z}
//  res_valid  out  1    result slot full; held until res_ready
//  res_ready  in   1    consumer takes result when res_valid & res_ready
//  busy       out  1    FSM not in IDLE
//  timeout    out  1    sticky watchdog flag (0 when macro absent)
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, all outputs 0 (empty=1), overflow/timeout cleared.
//  FIFO: push accepted if !full, or if full and a pop occurs the same cycle. A
//   dropped push sets overflow. Pointers wrap modulo DEPTH.
//  FSM (registered outputs, one state per cycle unless waiting):
//   IDLE      : if !empty && !res_valid -> LOAD. Otherwise stay.
//   LOAD      : cpu_in=head, cpu_load=1 -> START.
//   START     : cpu_in=head, cpu_s=1, pop FIFO -> WAIT_BUSY.
//   WAIT_BUSY : cpu_s=0; wait for cpu_w==0 -> WAIT_DONE.
//   WAIT_DONE : when cpu_w==1, register res_data=cpu_out, res_flags={N,V,Z},
//               set res_valid -> IDLE.
//  cpu_in holds last presented value outside LOAD/START. cpu_load and cpu_s are
//   exactly one cycle each and never overlap.
//  res_valid clears on the edge where res_ready=1. A new launch is blocked while
//   res_valid=1, so at most one unread result exists.
//  Minimum launch latency: cpu_load asserts 1 cycle after IDLE sees a non-empty FIFO.
//  A push into an empty FIFO while in IDLE is seen next cycle (no bypass).
//  Async reset mid-transaction: returns to IDLE, discards FIFO and result. No partial
//   result is ever presented.
// CONFIGURATION
//  FEEDER_TIMEOUT_EN defined: cycle counter runs in WAIT_BUSY/WAIT_DONE and clears
//   on entry. Reaching TIMEOUT_CYCLES sets timeout (sticky until reset) and returns
//   to IDLE without res_valid; the popped instruction is lost.
//  FEEDER_TIMEOUT_EN undefined: no counter; FSM waits indefinitely; timeout tied 0.
// TESTING (CPU stub: w drops the cycle after s, stays low 4 cycles, out=16'h0005, NVZ=000)
//  1 Push 16'hC0A0, res_ready=1 -> load one cycle, s next cycle, res_data=16'h0005,
//    res_flags=0, res_valid for 1 cycle.
//  2 Push DEPTH+1 instructions back-to-back while busy -> full=1, overflow=1,
//    exactly DEPTH results delivered in push order.
//  3 Hold res_ready=0 with 2 queued -> second load held until res_ready pulses;
//    res_data stays stable meanwhile.
//  4 Full FIFO, push during START -> push accepted, overflow stays 0.
//  5 Assert reset in WAIT_DONE -> next cycle busy=0, empty=1, res_valid=0; no result.
//  6 FEEDER_TIMEOUT_EN, stub never raises w -> timeout=1 after 64 cycles, busy=0,
//    res_valid=0.

Source files
------------

// File: rtl/p4_instr_feeder.sv
// p4_instr_feeder
//   Host-side initiator for the p4_cpu load/s/w handshake. Queues 16-bit
//   instructions in a small FIFO and presents them one at a time to the
//   CPU. Each instruction gets one load pulse and then one s pulse. The
//   feeder then watches w fall and rise again, captures the CPU result and
//   flags, and only then launches the next instruction.
//
// Optional feature macro: FEEDER_TIMEOUT_EN
//   When it is defined, a watchdog limits the time spent waiting on the CPU
//   to TIMEOUT_CYCLES. On expiry the transaction is abandoned and the sticky
//   timeout flag is set. When it is undefined, the feeder waits forever and
//   o_timeout is tied low.
//
// Ports
//   clk, reset                     clock (rising edge), async active-high reset
//   i_wr_en, i_wr_data             push an instruction into the FIFO
//   o_full, o_empty, o_overflow    FIFO status; overflow is sticky (push dropped)
//   o_cpu_in, o_cpu_load, o_cpu_s  instruction and strobes towards the CPU
//   i_cpu_w, i_cpu_out             CPU wait flag (1 = waiting) and result
//   i_cpu_N, i_cpu_V, i_cpu_Z      CPU condition flags
//   o_res_data, o_res_flags        captured result and {N,V,Z}
//   o_res_valid, i_res_ready       result slot handshake
//   o_busy                         transaction in progress (FSM not idle)
//   o_timeout                      sticky watchdog flag

module p4_instr_feeder #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_en,
  input  logic [15:0] i_wr_data,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_overflow,
  output logic [15:0] o_cpu_in,
  output logic        o_cpu_load,
  output logic        o_cpu_s,
  input  logic        i_cpu_w,
  input  logic [15:0] i_cpu_out,
  input  logic        i_cpu_N,
  input  logic        i_cpu_V,
  input  logic        i_cpu_Z,
  output logic [15:0] o_res_data,
  output logic [2:0]  o_res_flags,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  // Pointer wrap relies on DEPTH being a power of two.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_badCfg
    $error("p4_instr_feeder: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        r_state;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [15:0]   r_cpuIn;
  logic          r_cpuLoad;
  logic          r_cpuS;
  logic [15:0]   r_resData;
  logic [2:0]    r_resFlags;
  logic          r_resValid;

  logic          w_pop;
  logic          w_push;
  logic          w_expired;
  logic [15:0]   w_head;

  // The head leaves the FIFO on the START cycle, so a full FIFO can still
  // take a push in that same cycle.
  assign w_pop  = (r_state == START);
  assign w_push = i_wr_en && (!o_full || w_pop);
  assign w_head = r_mem[r_rdPtr];

  assign o_full      = (r_count == FullCount);
  assign o_empty     = (r_count == '0);
  assign o_overflow  = r_overflow;
  assign o_cpu_in    = r_cpuIn;
  assign o_cpu_load  = r_cpuLoad;
  assign o_cpu_s     = r_cpuS;
  assign o_res_data  = r_resData;
  assign o_res_flags = r_resFlags;
  assign o_res_valid = r_resValid;
  assign o_busy      = (r_state != IDLE);

  // FIFO storage needs no reset; the occupancy count decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_wr_data;
    end
  end

  // FIFO pointers, occupancy, and the sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (i_wr_en && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_timer;
  logic          r_timeout;

  // The watchdog restarts on each launch and counts every cycle spent
  // waiting on the CPU, across both wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == START) begin
      r_timer <= '0;
    end else if ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)) begin
      if (w_expired) begin
        r_timeout <= 1'b1;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign w_expired = (r_timer == TimerLast);
  assign o_timeout = r_timeout;
`else
  assign w_expired = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Transaction sequencer. All CPU-facing strobes are registered, so each
  // strobe is high for exactly the one cycle the FSM spends in its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cpuIn    <= '0;
      r_cpuLoad  <= 1'b0;
      r_cpuS     <= 1'b0;
      r_resData  <= '0;
      r_resFlags <= '0;
      r_resValid <= 1'b0;
    end else begin
      // The consumer drains the slot. A capture later in this block takes
      // priority, although a capture only happens while the slot is empty.
      if (i_res_ready) begin
        r_resValid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (!o_empty && !r_resValid) begin
            r_cpuIn   <= w_head;
            r_cpuLoad <= 1'b1;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          r_cpuLoad <= 1'b0;
          r_cpuS    <= 1'b1;
          r_state   <= START;
        end
        START: begin
          r_cpuS  <= 1'b0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (w_expired) begin
            r_state <= IDLE;
          end else if (!i_cpu_w) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (w_expired) begin
            r_state <= IDLE;
          end else if (i_cpu_w) begin
            r_resData  <= i_cpu_out;
            r_resFlags <= {i_cpu_N, i_cpu_V, i_cpu_Z};
            r_resValid <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p4_instr_feeder.sv
// tb_p4_instr_feeder
//   Drives p4_instr_feeder against a behavioural p4_cpu stub. After the s
//   pulse, the stub drops w for 4 cycles. Its result is 16'h0005 XOR
//   (instruction & stubMask), and its flags are bits [15:13] of the masked
//   instruction. With stubMask at 0, the stub returns 16'h0005 with flags
//   000. Expected results are queued as instructions are pushed and are
//   compared when the result handshake fires.

`timescale 1ns/1ps

module tb_p4_instr_feeder;

  localparam int DEPTH          = 4;
  localparam int TIMEOUT_CYCLES = 64;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  flags;
  } result_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wrEn;
  logic [15:0] wrData;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] cpuIn;
  logic        cpuLoad;
  logic        cpuS;
  logic        cpuW;
  logic [15:0] cpuOut;
  logic        cpuN;
  logic        cpuV;
  logic        cpuZ;
  logic [15:0] resData;
  logic [2:0]  resFlags;
  logic        resValid;
  logic        resReady;
  logic        busy;
  logic        timeout;

  logic        stubHang;
  logic [15:0] stubMask;
  logic [15:0] stubLatched;
  logic [15:0] stubMasked;
  logic [2:0]  stubCnt;

  int          checksTotal  = 0;
  int          checksPassed = 0;
  result_t     sb[$];
  result_t     monExp;

  p4_instr_feeder #(
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_wr_en(wrEn),
    .i_wr_data(wrData),
    .o_full(full),
    .o_empty(empty),
    .o_overflow(overflow),
    .o_cpu_in(cpuIn),
    .o_cpu_load(cpuLoad),
    .o_cpu_s(cpuS),
    .i_cpu_w(cpuW),
    .i_cpu_out(cpuOut),
    .i_cpu_N(cpuN),
    .i_cpu_V(cpuV),
    .i_cpu_Z(cpuZ),
    .o_res_data(resData),
    .o_res_flags(resFlags),
    .o_res_valid(resValid),
    .i_res_ready(resReady),
    .o_busy(busy),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // CPU stub: latches the instruction on load. On s it drops w and presents
  // the result, and it raises w again after 4 low cycles unless it is told
  // to hang.
  assign stubMasked = stubLatched & stubMask;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cpuW        <= 1'b1;
      stubCnt     <= '0;
      cpuOut      <= '0;
      {cpuN, cpuV, cpuZ} <= 3'b000;
      stubLatched <= '0;
    end else begin
      if (cpuLoad) begin
        stubLatched <= cpuIn;
      end
      if (cpuS) begin
        cpuW    <= 1'b0;
        stubCnt <= 3'd4;
        cpuOut  <= 16'h0005 ^ stubMasked;
        {cpuN, cpuV, cpuZ} <= stubMasked[15:13];
      end else if (!cpuW && !stubHang) begin
        if (stubCnt == 3'd1) begin
          cpuW <= 1'b1;
        end
        stubCnt <= stubCnt - 3'd1;
      end
    end
  end

  function automatic result_t expectedOf(input logic [15:0] d, input logic [15:0] mask);
    logic [15:0] m;
    result_t r;
    m       = d & mask;
    r.data  = 16'h0005 ^ m;
    r.flags = m[15:13];
    return r;
  endfunction

  // Result monitor: whenever the handshake is about to fire, pop the
  // oldest expected result and compare it.
  always @(negedge clk) begin
    if (!reset && resValid && resReady) begin
      checksTotal++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL result_unexpected got data=%h flags=%b, required no result", resData, resFlags);
      end else begin
        monExp = sb.pop_front();
        if (resData !== monExp.data || resFlags !== monExp.flags) begin
          $display("[TB] FAIL result_value got data=%h flags=%b, required data=%h flags=%b",
                   resData, resFlags, monExp.data, monExp.flags);
        end else begin
          checksPassed++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushInstr(input logic [15:0] d, input bit expectAccept);
    wrEn   = 1'b1;
    wrData = d;
    if (expectAccept) begin
      sb.push_back(expectedOf(d, stubMask));
    end
    step();
    wrEn = 1'b0;
  endtask

  task automatic doReset();
    #2;
    reset = 1'b1;
    sb.delete();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic drainAll();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || !empty) && n < 300) begin
      step();
      n++;
    end
    step();
    step();
    checksTotal++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      $display("[TB] FAIL drain got pending=%0d busy=%b, required pending=0 busy=0", sb.size(), busy);
    end else begin
      checksPassed++;
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    doReset();
    checksTotal++;
    if ({full, overflow, busy, resValid, cpuLoad, cpuS, timeout} !== 7'b0 || empty !== 1'b1) begin
      $display("[TB] FAIL reset_flags got full,ovf,busy,rv,load,s,to=%b empty=%b, required 0000000 empty=1",
               {full, overflow, busy, resValid, cpuLoad, cpuS, timeout}, empty);
    end else begin
      checksPassed++;
    end
    checksTotal++;
    if (cpuIn !== 16'h0000 || resData !== 16'h0000 || resFlags !== 3'b000) begin
      $display("[TB] FAIL reset_data got cpu_in=%h res=%h flags=%b, required 0000 0000 000", cpuIn, resData, resFlags);
    end else begin
      checksPassed++;
    end
  endtask

  task automatic test_single();
    int n;
    $display("[TB] test_single");
    stubMask = 16'h0000;
    resReady = 1'b1;
    pushInstr(16'hC0A0, 1'b1);
    checksTotal++;
    if (empty !== 1'b0 || cpuLoad !== 1'b0) begin
      $display("[TB] FAIL no_bypass got empty=%b load=%b, required empty=0 load=0", empty, cpuLoad);
    end else begin
      checksPassed++;
    end
    step();
    checksTotal++;
    if (cpuLoad !== 1'b1 || cpuS !== 1'b0 || cpuIn !== 16'hC0A0) begin
      $display("[TB] FAIL load_pulse got load=%b s=%b in=%h, required 1 0 c0a0", cpuLoad, cpuS, cpuIn);
    end else begin
      checksPassed++;
    end
    step();
    checksTotal++;
    if (cpuLoad !== 1'b0 || cpuS !== 1'b1 || cpuIn !== 16'hC0A0) begin
      $display("[TB] FAIL s_pulse got load=%b s=%b in=%h, required 0 1 c0a0", cpuLoad, cpuS, cpuIn);
    end else begin
      checksPassed++;
    end
    n = 0;
    while (!resValid && n < 40) begin
      step();
      n++;
    end
    checksTotal++;
    if (resValid !== 1'b1 || resData !== 16'h0005 || resFlags !== 3'b000 || busy !== 1'b0) begin
      $display("[TB] FAIL single_result got rv=%b data=%h flags=%b busy=%b, required 1 0005 000 0",
               resValid, resData, resFlags, busy);
    end else begin
      checksPassed++;
    end
    step();
    checksTotal++;
    if (resValid !== 1'b0) begin
      $display("[TB] FAIL valid_one_cycle got rv=%b, required 0", resValid);
    end else begin
      checksPassed++;
    end
    drainAll();
  endtask

  task automatic test_overflow();
    int n;
    $display("[TB] test_overflow");
    doReset();
    stubMask = 16'hFFFF;
    resReady = 1'b1;
    pushInstr(16'h1111, 1'b1);
    n = 0;
    while (!cpuS && n < 20) begin
      step();
      n++;
    end
    step();
    for (int i = 0; i < DEPTH; i++) begin
      pushInstr(16'hA001 + 16'(i) * 16'h2101, 1'b1);
    end
    checksTotal++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      $display("[TB] FAIL fill got full=%b ovf=%b, required full=1 ovf=0", full, overflow);
    end else begin
      checksPassed++;
    end
    pushInstr(16'hEEEE, 1'b0);
    checksTotal++;
    if (overflow !== 1'b1 || full !== 1'b1) begin
      $display("[TB] FAIL overflow got ovf=%b full=%b, required ovf=1 full=1", overflow, full);
    end else begin
      checksPassed++;
    end
    drainAll();
    checksTotal++;
    if (overflow !== 1'b1 || empty !== 1'b1) begin
      $display("[TB] FAIL overflow_sticky got ovf=%b empty=%b, required ovf=1 empty=1", overflow, empty);
    end else begin
      checksPassed++;
    end
  endtask

  task automatic test_hold();
    int n;
    int loadSeen;
    result_t first;
    $display("[TB] test_hold");
    doReset();
    stubMask = 16'hFFFF;
    resReady = 1'b0;
    first    = expectedOf(16'h3A01, stubMask);
    pushInstr(16'h3A01, 1'b1);
    pushInstr(16'h7A02, 1'b1);
    n = 0;
    while (!resValid && n < 40) begin
      step();
      n++;
    end
    loadSeen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cpuLoad) begin
        loadSeen++;
      end
      checksTotal++;
      if (resValid !== 1'b1 || resData !== first.data || cpuIn !== 16'h3A01) begin
        $display("[TB] FAIL hold_stable got rv=%b data=%h in=%h, required 1 %h 3a01", resValid, resData, cpuIn, first.data);
      end else begin
        checksPassed++;
      end
    end
    checksTotal++;
    if (loadSeen != 0 || busy !== 1'b0 || empty !== 1'b0) begin
      $display("[TB] FAIL hold_blocked got loads=%0d busy=%b empty=%b, required 0 0 0", loadSeen, busy, empty);
    end else begin
      checksPassed++;
    end
    resReady = 1'b1;
    step();
    resReady = 1'b0;
    n = 0;
    while (!resValid && n < 40) begin
      step();
      n++;
    end
    checksTotal++;
    if (resValid !== 1'b1) begin
      $display("[TB] FAIL second_result got rv=%b, required 1", resValid);
    end else begin
      checksPassed++;
    end
    resReady = 1'b1;
    drainAll();
  endtask

  task automatic test_push_during_start();
    int n;
    $display("[TB] test_push_during_start");
    doReset();
    stubMask = 16'hFFFF;
    resReady = 1'b0;
    pushInstr(16'h0D00, 1'b1);
    n = 0;
    while (!resValid && n < 40) begin
      step();
      n++;
    end
    for (int i = 1; i <= DEPTH; i++) begin
      pushInstr(16'h4F00 + 16'(i) * 16'h3011, 1'b1);
    end
    resReady = 1'b1;
    n = 0;
    while (!cpuS && n < 20) begin
      step();
      n++;
    end
    checksTotal++;
    if (cpuS !== 1'b1 || full !== 1'b1) begin
      $display("[TB] FAIL reach_start got s=%b full=%b, required s=1 full=1", cpuS, full);
    end else begin
      checksPassed++;
    end
    pushInstr(16'hF5F5, 1'b1);
    checksTotal++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      $display("[TB] FAIL push_on_pop got ovf=%b full=%b, required ovf=0 full=1", overflow, full);
    end else begin
      checksPassed++;
    end
    drainAll();
    checksTotal++;
    if (overflow !== 1'b0) begin
      $display("[TB] FAIL push_on_pop_ovf got ovf=%b, required 0", overflow);
    end else begin
      checksPassed++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int validSeen;
    $display("[TB] test_reset_mid");
    doReset();
    stubMask = 16'hFFFF;
    resReady = 1'b1;
    pushInstr(16'h4B01, 1'b1);
    pushInstr(16'h4B02, 1'b1);
    n = 0;
    while (cpuW && n < 20) begin
      step();
      n++;
    end
    step();
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    checksTotal++;
    if (busy !== 1'b0 || empty !== 1'b1 || resValid !== 1'b0) begin
      $display("[TB] FAIL reset_mid got busy=%b empty=%b rv=%b, required 0 1 0", busy, empty, resValid);
    end else begin
      checksPassed++;
    end
    step();
    reset = 1'b0;
    validSeen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (resValid || cpuLoad) begin
        validSeen++;
      end
    end
    checksTotal++;
    if (validSeen != 0 || empty !== 1'b1 || busy !== 1'b0) begin
      $display("[TB] FAIL reset_mid_quiet got activity=%0d empty=%b busy=%b, required 0 1 0", validSeen, empty, busy);
    end else begin
      checksPassed++;
    end
  endtask

  task automatic test_timeout();
`ifdef FEEDER_TIMEOUT_EN
    int n;
`endif
    $display("[TB] test_timeout");
    doReset();
`ifdef FEEDER_TIMEOUT_EN
    stubMask = 16'hFFFF;
    resReady = 1'b1;
    stubHang = 1'b1;
    pushInstr(16'h5C01, 1'b0);
    n = 0;
    while (!cpuS && n < 20) begin
      step();
      n++;
    end
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 200);
    checksTotal++;
    if (n != TIMEOUT_CYCLES + 1 || timeout !== 1'b1 || resValid !== 1'b0 || busy !== 1'b0) begin
      $display("[TB] FAIL timeout got cycles=%0d to=%b rv=%b busy=%b, required %0d 1 0 0",
               n, timeout, resValid, busy, TIMEOUT_CYCLES + 1);
    end else begin
      checksPassed++;
    end
    stubHang = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
    end
    checksTotal++;
    if (timeout !== 1'b1 || resValid !== 1'b0) begin
      $display("[TB] FAIL timeout_sticky got to=%b rv=%b, required 1 0", timeout, resValid);
    end else begin
      checksPassed++;
    end
    doReset();
    checksTotal++;
    if (timeout !== 1'b0) begin
      $display("[TB] FAIL timeout_reset got to=%b, required 0", timeout);
    end else begin
      checksPassed++;
    end
`else
    stubMask = 16'h0000;
    resReady = 1'b1;
    pushInstr(16'h5C01, 1'b1);
    drainAll();
    checksTotal++;
    if (timeout !== 1'b0) begin
      $display("[TB] FAIL timeout_tied got to=%b, required 0", timeout);
    end else begin
      checksPassed++;
    end
`endif
  endtask

  initial begin
    reset    = 1'b1;
    wrEn     = 1'b0;
    wrData   = '0;
    resReady = 1'b0;
    stubHang = 1'b0;
    stubMask = 16'h0000;
    test_reset();
    test_single();
    test_overflow();
    test_hold();
    test_push_during_start();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  // Hard stop if the run ever loses its way.
  initial begin
    #200000;
    $display("[TB] FAIL global_watchdog got time=%0t, required completion", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
